// File: rtl/regfile_pkg.sv
// Shared register-file constants and the writeback grant encoding.
package regfile_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 5;

  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

  typedef enum logic {
    GRANT_A = 1'b0,
    GRANT_B = 1'b1
  } grant_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way writeback arbiter: round-robin on last grant, or fixed priority to A.
module rr_arb2
  import regfile_pkg::*;
#(
  parameter bit PrioFixed = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_a_i,
  input  logic req_b_i,
  output logic gnt_a_o,
  output logic gnt_b_o
);

  grant_e last_q, last_d;

  always_comb begin
    gnt_a_o = 1'b0;
    gnt_b_o = 1'b0;
    if (req_a_i && req_b_i) begin
      if (PrioFixed || (last_q == GRANT_B)) begin
        gnt_a_o = 1'b1;
      end else begin
        gnt_b_o = 1'b1;
      end
    end else begin
      gnt_a_o = req_a_i;
      gnt_b_o = req_b_i;
    end
  end

  // Grants only assert alongside their request, so every grant is a handshake.
  always_comb begin
    last_d = last_q;
    if (gnt_a_o) begin
      last_d = GRANT_A;
    end else if (gnt_b_o) begin
      last_d = GRANT_B;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= GRANT_B;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/reg_wr_arbiter.sv
// Shares the register-file write port between ALU (A) and load (B) writeback.
// Optional RF_BYPASS_EN adds combinational read forwarding from the output stage.
module reg_wr_arbiter #(
  parameter int unsigned DATA_W     = regfile_pkg::DATA_W,
  parameter int unsigned ADDR_W     = regfile_pkg::ADDR_W,
  parameter int unsigned PRIO_FIXED = 0,
  parameter int unsigned CNT_W      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  output logic              rf_we3,
  output logic [ADDR_W-1:0] rf_wa3,
  output logic [DATA_W-1:0] rf_wd3,
  output logic              busy,
`ifdef RF_BYPASS_EN
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  input  logic [DATA_W-1:0] rf_rd1,
  input  logic [DATA_W-1:0] rf_rd2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
`endif
  output logic [CNT_W-1:0]  stall_cnt
);
  import regfile_pkg::*;

  logic              we_q, we_d;
  logic              busy_q, busy_d;
  logic [ADDR_W-1:0] wa_q, wa_d;
  logic [DATA_W-1:0] wd_q, wd_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              stall;

  rr_arb2 #(
    .PrioFixed (PRIO_FIXED != 0)
  ) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_a_i (a_valid),
    .req_b_i (b_valid),
    .gnt_a_o (a_ready),
    .gnt_b_o (b_ready)
  );

  // Address/data hold when idle; only the enable and busy flag fall back to zero.
  always_comb begin
    busy_d = 1'b0;
    wa_d   = wa_q;
    wd_d   = wd_q;
    if (a_ready) begin
      busy_d = 1'b1;
      wa_d   = a_addr;
      wd_d   = a_data;
    end else if (b_ready) begin
      busy_d = 1'b1;
      wa_d   = b_addr;
      wd_d   = b_data;
    end
    we_d = busy_d && (wa_d != ADDR_W'(REG_ZERO));
  end

  assign stall = (a_valid && !a_ready) || (b_valid && !b_ready);

  always_comb begin
    cnt_d = cnt_q;
    if (stall && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q   <= 1'b0;
      busy_q <= 1'b0;
      wa_q   <= '0;
      wd_q   <= '0;
      cnt_q  <= '0;
    end else begin
      we_q   <= we_d;
      busy_q <= busy_d;
      wa_q   <= wa_d;
      wd_q   <= wd_d;
      cnt_q  <= cnt_d;
    end
  end

  assign rf_we3    = we_q;
  assign rf_wa3    = wa_q;
  assign rf_wd3    = wd_q;
  assign busy      = busy_q;
  assign stall_cnt = cnt_q;

`ifdef RF_BYPASS_EN
  // Covers the cycle between output-stage load and register-file commit.
  always_comb begin
    rd1 = rf_rd1;
    rd2 = rf_rd2;
    if (we_q && (wa_q == ra1)) begin
      rd1 = wd_q;
    end
    if (we_q && (wa_q == ra2)) begin
      rd2 = wd_q;
    end
  end
`endif

endmodule

// File: tb/tb_reg_wr_arbiter.sv
// Bench for reg_wr_arbiter: vector table plus scoreboard of output-stage contents.
module tb_reg_wr_arbiter;

  localparam int unsigned DW  = 32;
  localparam int unsigned AW  = 5;
  localparam int unsigned CW  = 8;
  localparam int unsigned CWF = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          a_valid = 1'b0, b_valid = 1'b0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [DW-1:0] a_data = '0, b_data = '0;

  logic          a_ready, b_ready, rf_we3, busy;
  logic [AW-1:0] rf_wa3;
  logic [DW-1:0] rf_wd3;
  logic [CW-1:0] stall_cnt;

  logic          fx_a_ready, fx_b_ready, fx_we3, fx_busy;
  logic [AW-1:0] fx_wa3;
  logic [DW-1:0] fx_wd3;
  logic [CWF-1:0] fx_stall;

  logic [DW-1:0] mem [32] = '{default: '0};

`ifdef RF_BYPASS_EN
  logic [AW-1:0] ra1 = '0, ra2 = '0;
  logic [DW-1:0] rf_rd1, rf_rd2, rd1, rd2, fx_rd1, fx_rd2;
  assign rf_rd1 = mem[ra1];
  assign rf_rd2 = mem[ra2];
`endif

  always #5 clk = ~clk;

  // Register file fed by the round-robin instance.
  always @(posedge clk) begin
    if (rf_we3) mem[rf_wa3] <= rf_wd3;
  end

  reg_wr_arbiter #(.DATA_W(DW), .ADDR_W(AW), .PRIO_FIXED(0), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(b_ready),
    .rf_we3(rf_we3), .rf_wa3(rf_wa3), .rf_wd3(rf_wd3), .busy(busy),
`ifdef RF_BYPASS_EN
    .ra1(ra1), .ra2(ra2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2), .rd1(rd1), .rd2(rd2),
`endif
    .stall_cnt(stall_cnt)
  );

  reg_wr_arbiter #(.DATA_W(DW), .ADDR_W(AW), .PRIO_FIXED(1), .CNT_W(CWF)) dut_fx (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(fx_a_ready),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data), .b_ready(fx_b_ready),
    .rf_we3(fx_we3), .rf_wa3(fx_wa3), .rf_wd3(fx_wd3), .busy(fx_busy),
`ifdef RF_BYPASS_EN
    .ra1(ra1), .ra2(ra2), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2), .rd1(fx_rd1), .rd2(fx_rd2),
`endif
    .stall_cnt(fx_stall)
  );

  typedef struct packed {
    logic          av;
    logic [AW-1:0] aa;
    logic [DW-1:0] ad;
    logic          bv;
    logic [AW-1:0] ba;
    logic [DW-1:0] bd;
    logic          ea, eb, fa, fb;
  } vec_t;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic          busy;
  } sb_t;

  sb_t           sbq[$];
  vec_t          vecs[$];
  logic [AW-1:0] m_wa = '0;
  logic [DW-1:0] m_wd = '0;
  int            n_chk = 0;
  int            n_fail = 0;

  function automatic vec_t mk(input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                              input logic bv, input logic [AW-1:0] ba, input logic [DW-1:0] bd,
                              input logic ea, input logic eb, input logic fa, input logic fb);
    vec_t v;
    v.av = av; v.aa = aa; v.ad = ad;
    v.bv = bv; v.ba = ba; v.bd = bd;
    v.ea = ea; v.eb = eb; v.fa = fa; v.fb = fb;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input vec_t v);
    sb_t e;
    e.busy = v.ea | v.eb;
    if (v.ea) begin
      m_wa = v.aa;
      m_wd = v.ad;
    end else if (v.eb) begin
      m_wa = v.ba;
      m_wd = v.bd;
    end
    e.wa = m_wa;
    e.wd = m_wd;
    e.we = e.busy && (m_wa != '0);
    sbq.push_back(e);
  endtask

  // Drive one cycle, check readies and the output stage loaded by the previous cycle.
  task automatic apply(input vec_t v, input int idx);
    sb_t e;
    a_valid = v.av; a_addr = v.aa; a_data = v.ad;
    b_valid = v.bv; b_addr = v.ba; b_data = v.bd;
    @(negedge clk);
    chk($sformatf("a_ready[%0d]", idx), {63'd0, a_ready}, {63'd0, v.ea});
    chk($sformatf("b_ready[%0d]", idx), {63'd0, b_ready}, {63'd0, v.eb});
    chk($sformatf("fx_a_ready[%0d]", idx), {63'd0, fx_a_ready}, {63'd0, v.fa});
    chk($sformatf("fx_b_ready[%0d]", idx), {63'd0, fx_b_ready}, {63'd0, v.fb});
    if (sbq.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL scoreboard_empty[%0d]: actual=0 required=1", idx);
    end else begin
      e = sbq.pop_front();
      chk($sformatf("rf_we3[%0d]", idx), {63'd0, rf_we3}, {63'd0, e.we});
      chk($sformatf("rf_wa3[%0d]", idx), {59'd0, rf_wa3}, {59'd0, e.wa});
      chk($sformatf("rf_wd3[%0d]", idx), {32'd0, rf_wd3}, {32'd0, e.wd});
      chk($sformatf("busy[%0d]", idx), {63'd0, busy}, {63'd0, e.busy});
    end
    push_exp(v);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t idle;
    idle = mk(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    vecs.push_back(mk(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b1, 1'b0));
    vecs.push_back(idle);
    vecs.push_back(mk(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hCAFEBABE, 1'b0, 1'b1, 1'b0, 1'b1));
    vecs.push_back(idle);
    for (int i = 0; i < 4; i++) begin
      vecs.push_back(mk(1'b1, 5'd3, 32'h11111111, 1'b1, 5'd4, 32'h22222222,
                        (i % 2) == 0, (i % 2) == 1, 1'b1, 1'b0));
    end
    vecs.push_back(mk(1'b1, 5'd3, 32'h11111111, 1'b1, 5'd4, 32'h22222222,
                      1'b1, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'h22222222, 1'b0, 1'b1, 1'b0, 1'b1));
    vecs.push_back(mk(1'b1, 5'd7, 32'h77777777, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 5'd6, 32'hAAAA0001, 1'b1, 5'd6, 32'hBBBB0002,
                      1'b0, 1'b1, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 5'd6, 32'hAAAA0001, 1'b1, 5'd6, 32'hBBBB0002,
                      1'b1, 1'b0, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 5'd1, 32'h01010101, 1'b1, 5'd2, 32'h02020202,
                      1'b0, 1'b1, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 5'd1, 32'h01010101, 1'b1, 5'd2, 32'h02020202,
                      1'b1, 1'b0, 1'b1, 1'b0));
    vecs.push_back(idle);
    vecs.push_back(idle);

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_we3", {63'd0, rf_we3}, 64'd0);
    chk("reset_wa3", {59'd0, rf_wa3}, 64'd0);
    chk("reset_wd3", {32'd0, rf_wd3}, 64'd0);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_stall", {56'd0, stall_cnt}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    sbq.push_back('0);

    foreach (vecs[i]) apply(vecs[i], i);

    chk("stall_cnt_rr", {56'd0, stall_cnt}, 64'd9);
    chk("stall_cnt_fx_sat", {61'd0, fx_stall}, 64'd7);
    chk("mem_r0", {32'd0, mem[0]}, 64'd0);
    chk("mem_r1", {32'd0, mem[1]}, 64'h01010101);
    chk("mem_r2", {32'd0, mem[2]}, 64'h02020202);
    chk("mem_r3", {32'd0, mem[3]}, 64'h11111111);
    chk("mem_r4", {32'd0, mem[4]}, 64'h22222222);
    chk("mem_r5", {32'd0, mem[5]}, 64'hDEADBEEF);
    chk("mem_r6", {32'd0, mem[6]}, 64'hAAAA0001);
    chk("mem_r7", {32'd0, mem[7]}, 64'h77777777);

    // Read of a register during the cycle its write sits in the output stage.
    apply(mk(1'b1, 5'd9, 32'hCAFEBABE, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b1, 1'b0), 100);
`ifdef RF_BYPASS_EN
    ra1 = 5'd9;
    ra2 = 5'd5;
    #1;
    chk("bypass_rd1", {32'd0, rd1}, 64'hCAFEBABE);
    chk("bypass_rf_rd1_old", {32'd0, rf_rd1}, 64'd0);
    chk("bypass_rd2_passthru", {32'd0, rd2}, 64'hDEADBEEF);
`endif
    apply(idle, 101);
    chk("mem_r9_t2", {32'd0, mem[9]}, 64'hCAFEBABE);

    // Reset asserted while a write to r7 is in the output stage.
    apply(mk(1'b1, 5'd7, 32'h12345678, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b1, 1'b0), 200);
    chk("pre_reset_we3", {63'd0, rf_we3}, 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_we3", {63'd0, rf_we3}, 64'd0);
    chk("async_reset_busy", {63'd0, busy}, 64'd0);
    chk("async_reset_wa3", {59'd0, rf_wa3}, 64'd0);
    chk("async_reset_wd3", {32'd0, rf_wd3}, 64'd0);
    chk("async_reset_stall", {56'd0, stall_cnt}, 64'd0);
    a_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("mem_r7_kept", {32'd0, mem[7]}, 64'h77777777);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    sbq.delete();
    sbq.push_back('0);
    m_wa = '0;
    m_wd = '0;

    // last_grant returns to B, so A wins the first tie after reset.
    apply(mk(1'b1, 5'd8, 32'h88888888, 1'b1, 5'd10, 32'h0A0A0A0A, 1'b1, 1'b0, 1'b1, 1'b0), 300);
    apply(idle, 301);
    apply(idle, 302);
    chk("mem_r8", {32'd0, mem[8]}, 64'h88888888);
    chk("stall_after_reset", {56'd0, stall_cnt}, 64'd1);
    chk("fx_stall_after_reset", {61'd0, fx_stall}, 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_wr_arbiter.md
Name: reg_wr_arbiter

Overview:
Shares the register file's single write port (we3/wa3/wd3) between two writeback requesters: A (ALU result) and B (load/memory result). Arbitration is round-robin or fixed-priority, per a parameter. The block registers the winning write into a one-cycle output stage that drives the register file, and drops writes to $0. It sits between the writeback sources and reg_file.

Parameters:
DATA_W, 32, width of write data and read data
ADDR_W, 5, register address width (32 registers)
PRIO_FIXED, 0, 0 = round-robin; 1 = A always wins ties
CNT_W, 8, width of the saturating stall counter

Ports:
clk  in  1  clock; all flops on rising edge
rst_n  in  1  asynchronous active-low reset
a_valid  in  1  requester A has a write pending; must hold valid/addr/data stable until a_ready
a_addr  in  ADDR_W  A destination register
a_data  in  DATA_W  A write data
a_ready  out  1  A handshake completes this cycle
b_valid  in  1  requester B pending write, same rules as A
b_addr  in  ADDR_W  B destination register
b_data  in  DATA_W  B write data
b_ready  out  1  B handshake completes this cycle
rf_we3  out  1  register file write enable
rf_wa3  out  ADDR_W  register file write address
rf_wd3  out  DATA_W  register file write data
busy  out  1  output stage holds a valid write (rf_we3 or dropped-$0 slot)
stall_cnt  out  CNT_W  saturating count of cycles in which a valid requester was not granted
ra1, ra2  in  ADDR_W  read addresses (present only with RF_BYPASS_EN)
rf_rd1, rf_rd2  in  DATA_W  raw register file read data (present only with RF_BYPASS_EN)
rd1, rd2  out  DATA_W  forwarded read data (present only with RF_BYPASS_EN)

Behaviour:
- Reset (async, rst_n=0):
  - rf_we3=0, rf_wa3=0, rf_wd3=0, busy=0, stall_cnt=0.
  - last_grant=B, so A wins the first tie.
  - An in-flight output-stage write is discarded immediately.
- Grant logic (combinational, same cycle):
  - Only one valid requester: that one is granted.
  - Both valid, PRIO_FIXED=0: the requester not in last_grant is granted.
  - Both valid, PRIO_FIXED=1: A is granted.
  - a_ready = a_valid & grant_a; b_ready = b_valid & grant_b. At most one ready per cycle.
  - ready never asserts without the matching valid.
- Handshake cycle T (x_valid & x_ready):
  - last_grant updates to the winner at the edge ending T.
  - Output stage loads the winner's addr/data at that edge.
- Cycle T+1:
  - rf_we3=1, rf_wa3/rf_wd3 = captured values, busy=1.
  - The register file commits at the edge ending T+1.
  - Latency: handshake to register file commit = 2 edges.
- $0 writes: the handshake completes normally, but rf_we3 stays 0 in T+1.
  - busy=1 and rf_wa3=0 in T+1; rf_wd3 is loaded anyway.
- No grant in a cycle: rf_we3=0 next cycle; rf_wa3/rf_wd3 hold their last values.
- Throughput: one write per cycle, back-to-back. Alternating grants under continuous contention (round-robin).
- Same register from both requesters in consecutive grants: commits in grant order, so the later grant's data persists.
- stall_cnt:
  - Increments each cycle in which (a_valid & ~a_ready) | (b_valid & ~b_ready).
  - Saturates at 2^CNT_W-1 and does not wrap.
  - Cleared only by reset.
- Widths: no arithmetic on data; addr compare is an ADDR_W-bit equality.

Optional Feature:
Macro RF_BYPASS_EN.
- Defined:
  - rd1 = (rf_we3 & rf_wa3==ra1) ? rf_wd3 : rf_rd1; rd2 likewise with ra2/rf_rd2.
  - Combinational forwarding covers the T+1 window before commit.
  - ra==0 always returns rf_rd (rf_we3 is never set for $0).
- Not defined: the ra1/ra2/rf_rd1/rf_rd2/rd1/rd2 ports are absent and no forwarding logic exists. Consumers read the register file directly and see the new value from cycle T+2.

Decomposition:
- Shared package regfile_pkg:
  - DATA_W/ADDR_W constants
  - REG_ZERO = 0
  - grant encoding typedef (GRANT_A, GRANT_B)
- One natural sub-module: rr_arb2, the 2-way round-robin/fixed arbiter holding last_grant and producing one-hot grant.
- Output stage, stall counter and bypass muxes stay in the top.

Test Plan:
1. Reset, then A writes addr 5 = DEADBEEF, B idle: a_ready in T; rf_we3=1, wa3=5, wd3=DEADBEEF in T+1; reg_file r5 reads DEADBEEF at T+2.
2. A (r3=11111111) and B (r4=22222222) both valid for 4 cycles, PRIO_FIXED=0: grants A,B,A,B. stall_cnt=4 after 4 cycles (one stalled requester each cycle).
3. B writes addr 0 = CAFEBABE: b_ready=1; rf_we3=0 and busy=1 in T+1; reading r0 returns 0.
4. PRIO_FIXED=1, both valid continuously: A granted every cycle, b_ready stays 0. Drop a_valid: B granted the same cycle.
5. Assert rst_n=0 mid-cycle in T+1 of a write to r7: rf_we3 drops immediately, r7 is unchanged, and stall_cnt=0.
6. RF_BYPASS_EN, A writes r9=CAFEBABE, ra1=9 in T+1: rd1=CAFEBABE in T+1 while rf_rd1 still shows the old value. Without the macro, the bench reads r9 at T+2 and gets CAFEBABE.
